instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage for the 16-bit CPU. Owns the program counter, drives the read address of the unified memory's port A, and absorbs that memory's one-cycle synchronous read latency. Presents fetched instructions to decode over a valid/ready handshake with a 2-entry skid buffer so decode back-pressure never loses or duplicates a word. Branch/jump redirects from execute squash all in-flight and buffered fetches.

## Interface
- ADDR_W, 15, word-address width; matches the memory's address port.
- DATA_W, 16, instruction width.
- RESET_PC, 15'h0000, first fetch address after reset.
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  out  ADDR_W  to memory port A address. Port A write enable is tied low at top level.
- mem_data  in  DATA_W  memory port A read data; valid the cycle after the address is sampled.
- redirect  in  1  one-cycle pulse from execute: flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address, valid with redirect.
- instr_valid  out  1  buffer head holds a valid instruction.
- instr  out  DATA_W  instruction word at buffer head.
- instr_pc  out  ADDR_W  address the head instruction was fetched from.
- instr_ready  in  1  decode accepts the head this cycle; a pop occurs when instr_valid & instr_ready.

## Operation
- State machine: BOOT, RUN. Reset forces BOOT. BOOT lasts exactly one cycle: no issue, then RUN. RUN is permanent until reset.
- A redirect in BOOT loads pc and still transitions to RUN. It issues in that same cycle, which is the one exception to "no issue in BOOT".
- mem_addr is combinational: redirect ? redirect_pc : pc.
- An issue occurs when the state is RUN (or redirect is asserted) and buffer_count + inflight - pop < 2. The memory reads every cycle, but only issued reads are tracked.
- On an issue edge:
  - pc <= mem_addr + 1, modulo 2^ADDR_W, so 0x7FFF wraps to 0x0000.
  - inflight <= 1 and inflight_pc <= mem_addr.
- With no issue: inflight <= 0 and pc holds.
- When inflight = 1 and the read was not squashed, at the next edge {mem_data, inflight_pc} is pushed into the buffer.
- Redirect:
  - The buffer is cleared.
  - Any in-flight read is squashed: its data is discarded at the next edge.
  - The redirect_pc read is issued in the same cycle.
- Simultaneous redirect and pop: redirect wins. The popped word counts as consumed, and everything else is flushed.
- Simultaneous push and pop: count is unchanged and FIFO order is kept.
- The buffer never overflows, because the issue rule reserves a slot for every in-flight read. A push into a full buffer is an assertion failure.

## Timing
- Reset values (asynchronous, immediate): state=BOOT, pc=RESET_PC, inflight=0, buffer empty, instr_valid=0, instr=0, instr_pc=0. During reset mem_addr equals RESET_PC.
- Latency: an address issued at edge E produces data captured at E+1, so instr_valid is high in the cycle after E+1. After reset release, the first instr_valid appears after the 3rd edge (BOOT, issue, capture).
- Redirect latency: a redirect in cycle N gives instr_valid with instr_pc=redirect_pc after edge N+2. Stale instructions are never visible after edge N+1.
- Throughput: one instruction per cycle with instr_ready held high.
- Outputs instr, instr_pc and instr_valid come directly from buffer registers and hold stable while instr_valid & !instr_ready.

## Structure
- Shared package/header `cpu_defs`: ADDR_W, DATA_W, RESET_PC, fetch state encodings (BOOT=0, RUN=1).
- Sub-module `fetch_skid_buffer`: 2-entry FIFO of {DATA_W data, ADDR_W pc} with push, pop, flush, count[1:0], and head outputs. Flush has priority over push.
- The top level holds pc, the state machine, inflight/squash logic and the issue computation.

## Test plan
- Reset, preload mem[0..3]=16'h1111,16'h2222,16'h3333,16'h4444, ready=1 → instr_valid first high after the 3rd edge post-release, then instr/instr_pc = 1111/0, 2222/1, 3333/2, 4444/3 on consecutive cycles.
- Drop ready for 5 cycles once 16'h1111 is valid → instr holds 1111 and mem_addr stalls. After ready returns, the sequence continues 2222, 3333, … with no gap, loss or repeat.
- Redirect to 15'h0100 with buffer full and a read in flight → the next valid instruction has instr_pc=0x0100 and data mem[0x100], and no stale word appears after the redirect edge.
- Redirect to 15'h7FFF, ready=1 → instr_pc sequence 0x7FFF, 0x0000, 0x0001.
- Redirect in the same cycle as a pop → the popped word is accepted once and the next valid is redirect_pc. A redirect during BOOT is honoured.
- Assert reset_n low mid-stream between clock edges → instr_valid, instr and instr_pc are 0 immediately. After release the fetch restarts from RESET_PC.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared widths, reset vector and fetch state encodings for the 16-bit CPU.
package cpu_defs;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 15'h0000;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetched {instruction, pc}; entry 0 is always the head.
module fetch_skid_buffer
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:0] push_pc,
  output logic [1:0]        count,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data,
  output logic [ADDR_W-1:0] head_pc
);
  logic [DATA_W-1:0] data_reg  [2];
  logic [DATA_W-1:0] data_next [2];
  logic [ADDR_W-1:0] pc_reg    [2];
  logic [ADDR_W-1:0] pc_next   [2];
  logic [1:0]        count_reg;
  logic [1:0]        count_next;
  logic [0:0]        wr_idx;

  always_comb begin
    data_next  = data_reg;
    pc_next    = pc_reg;
    count_next = count_reg;
    wr_idx     = 1'b0;
    // Flush beats push; stale entries are left in place but become invisible.
    if (flush) begin
      count_next = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          wr_idx            = count_reg[0];
          data_next[wr_idx] = push_data;
          pc_next[wr_idx]   = push_pc;
          count_next        = count_reg + 2'd1;
        end
        2'b01: begin
          data_next[0] = data_reg[1];
          pc_next[0]   = pc_reg[1];
          count_next   = count_reg - 2'd1;
        end
        2'b11: begin
          data_next[0]      = data_reg[1];
          pc_next[0]        = pc_reg[1];
          wr_idx            = (count_reg == 2'd2) ? 1'b1 : 1'b0;
          data_next[wr_idx] = push_data;
          pc_next[wr_idx]   = push_pc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        data_reg[i] <= '0;
        pc_reg[i]   <= '0;
      end
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < 2; i++) begin
        data_reg[i] <= data_next[i];
        pc_reg[i]   <= pc_next[i];
      end
    end
  end

  assign count      = count_reg;
  assign head_valid = (count_reg != 2'd0);
  assign head_data  = data_reg[0];
  assign head_pc    = pc_reg[0];
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the pc, issues reads to memory port A, tracks the one
// outstanding read and hands words to decode through a 2-entry skid buffer.
module instruction_fetch
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);
  localparam logic [ADDR_W-1:0] PC_STEP = 1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic              inflight_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic [1:0]        buf_count;
  logic              pop;
  logic              push;
  logic [2:0]        occupancy;
  logic              issue;

  assign mem_addr  = redirect ? redirect_pc : pc_reg;
  assign pop       = instr_valid & instr_ready;
  // A redirect squashes an in-flight read by flushing the buffer on the same edge
  // the stale word would have landed.
  assign push      = inflight_reg;
  assign occupancy = {1'b0, buf_count} + {2'b00, inflight_reg} - {2'b00, pop};
  // Redirect always issues: the flush frees every slot the occupancy counts.
  assign issue     = redirect | ((state_reg == ST_RUN) && (occupancy < 3'd2));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_BOOT;
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      state_reg    <= ST_RUN;
      inflight_reg <= issue;
      if (issue) begin
        pc_reg          <= mem_addr + PC_STEP;
        inflight_pc_reg <= mem_addr;
      end
    end
  end

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .flush      (redirect),
    .push_data  (mem_data),
    .push_pc    (inflight_pc_reg),
    .count      (buf_count),
    .head_valid (instr_valid),
    .head_data  (instr),
    .head_pc    (instr_pc)
  );

  no_overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !redirect && !pop && (buf_count == 2'd2)));
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory model, stream-level reference model and
// directed plus randomized stimulus.
module tb_instruction_fetch;
  import cpu_defs::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  logic [DATA_W-1:0] mem [0:32767];

  int tests = 0;
  int fails = 0;
  int pops  = 0;

  instruction_fetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_data <= mem[mem_addr];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: the accepted stream is consecutive addresses starting at
  // RESET_PC or the latest redirect target, each paired with its memory word.
  logic [ADDR_W-1:0] exp_pc;
  int                rd_age = 3;
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_instr;
  logic [ADDR_W-1:0] prev_pc;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", {31'b0, instr_valid}, 32'd0);
      chk("rst_instr", {16'b0, instr}, 32'd0);
      chk("rst_pc", {17'b0, instr_pc}, 32'd0);
      chk("rst_addr", {17'b0, mem_addr}, {17'b0, RESET_PC});
      exp_pc    = RESET_PC;
      rd_age    = 3;
      prev_hold = 1'b0;
    end else begin
      if (rd_age < 3) rd_age++;
      if (rd_age == 1) chk("stale_visible", {31'b0, instr_valid}, 32'd0);
      if (rd_age == 2) chk("redirect_latency", {31'b0, instr_valid}, 32'd1);
      if (prev_hold) begin
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_instr", {16'b0, instr}, {16'b0, prev_instr});
        chk("hold_pc", {17'b0, instr_pc}, {17'b0, prev_pc});
      end
      if (instr_valid && instr_ready) begin
        chk("stream_pc", {17'b0, instr_pc}, {17'b0, exp_pc});
        chk("stream_data", {16'b0, instr}, {16'b0, mem[exp_pc]});
        exp_pc = exp_pc + 15'd1;
        pops++;
      end
      prev_hold  = instr_valid && !instr_ready && !redirect;
      prev_instr = instr;
      prev_pc    = instr_pc;
      if (redirect) begin
        exp_pc = redirect_pc;
        rd_age = 0;
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(string name, logic [ADDR_W-1:0] pc, logic [DATA_W-1:0] data);
    chk({name, "_valid"}, {31'b0, instr_valid}, 32'd1);
    chk({name, "_pc"}, {17'b0, instr_pc}, {17'b0, pc});
    chk({name, "_instr"}, {16'b0, instr}, {16'b0, data});
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[15'h0100] = 16'hA5A5;
    mem[15'h7FFF] = 16'h7777;
    mem[15'h0200] = 16'hB2B2;
    mem[15'h0300] = 16'hC3C3;

    reset_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Power-up: first valid after the 3rd edge, then one word per cycle.
    @(negedge clk);
    @(negedge clk); chk("boot_e1", {31'b0, instr_valid}, 32'd0);
    @(negedge clk); chk("boot_e2", {31'b0, instr_valid}, 32'd0);
    @(negedge clk); expect_head("seq0", 15'd0, 16'h1111);
    @(negedge clk); expect_head("seq1", 15'd1, 16'h2222);
    @(negedge clk); expect_head("seq2", 15'd2, 16'h3333);
    @(negedge clk); expect_head("seq3", 15'd3, 16'h4444);

    // Back-pressure: hold 1111 for five cycles, fetch address stalls at 2.
    drive_edge(); reset_n = 1'b0; instr_ready = 1'b0;
    drive_edge(); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      expect_head("stall", 15'd0, 16'h1111);
      chk("stall_addr", {17'b0, mem_addr}, 32'd2);
      if (i < 4) @(negedge clk);
    end
    drive_edge(); instr_ready = 1'b1;
    @(negedge clk); expect_head("resume0", 15'd0, 16'h1111);
    @(negedge clk); expect_head("resume1", 15'd1, 16'h2222);
    @(negedge clk); expect_head("resume2", 15'd2, 16'h3333);
    @(negedge clk); expect_head("resume3", 15'd3, 16'h4444);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); chk("throughput", {31'b0, instr_valid}, 32'd1);
    end

    // Redirect with a buffered word and a read in flight.
    drive_edge(); instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 15'h0100;
    drive_edge(); redirect = 1'b0;
    @(negedge clk); chk("redir_flush", {31'b0, instr_valid}, 32'd0);
    @(negedge clk); expect_head("redir100", 15'h0100, 16'hA5A5);
    repeat (3) drive_edge();
    redirect = 1'b1; redirect_pc = 15'h0180;
    drive_edge(); redirect = 1'b0;
    @(negedge clk); chk("full_flush", {31'b0, instr_valid}, 32'd0);

    // Wrap at the top of the address space.
    drive_edge(); instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 15'h7FFF;
    drive_edge(); redirect = 1'b0;
    @(negedge clk);
    @(negedge clk); expect_head("wrap0", 15'h7FFF, 16'h7777);
    @(negedge clk); expect_head("wrap1", 15'h0000, 16'h1111);
    @(negedge clk); expect_head("wrap2", 15'h0001, 16'h2222);

    // Redirect coinciding with a pop.
    drive_edge(); redirect = 1'b1; redirect_pc = 15'h0200;
    @(negedge clk); chk("pop_redir_valid", {31'b0, instr_valid}, 32'd1);
    drive_edge(); redirect = 1'b0;
    @(negedge clk); chk("pop_redir_flush", {31'b0, instr_valid}, 32'd0);
    @(negedge clk); expect_head("pop_redir", 15'h0200, 16'hB2B2);

    // Redirect during BOOT is honoured.
    drive_edge(); reset_n = 1'b0;
    drive_edge(); reset_n = 1'b1; redirect = 1'b1; redirect_pc = 15'h0300;
    drive_edge(); redirect = 1'b0;
    @(negedge clk); chk("boot_redir_e1", {31'b0, instr_valid}, 32'd0);
    @(negedge clk); expect_head("boot_redir", 15'h0300, 16'hC3C3);

    // Asynchronous reset between edges clears outputs immediately.
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, instr_valid}, 32'd0);
    chk("async_instr", {16'b0, instr}, 32'd0);
    chk("async_pc", {17'b0, instr_pc}, 32'd0);
    chk("async_addr", {17'b0, mem_addr}, 32'd0);
    drive_edge(); reset_n = 1'b1;
    repeat (4) @(negedge clk);
    expect_head("restart", 15'd0, 16'h1111);

    // Randomized traffic checked by the stream model.
    for (int i = 0; i < 3000; i++) begin
      drive_edge();
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = 15'h7FFE + 15'($urandom_range(0, 1));
      else
        redirect_pc = 15'($urandom);
    end
    drive_edge(); redirect = 1'b0; instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    tests++;
    if (pops < 100) begin
      fails++;
      $display("FAIL pop_count: got %0d expected at least 100", pops);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
